// File: rtl/datapath_pkg.sv
// Shared issue-stage types: FUST slot states, functional-unit indices and age-matrix rows.
package datapath_pkg;

  localparam int NUM_FU = 5;

  localparam int FU_IDX_ALU  = 0;
  localparam int FU_IDX_LDST = 1;
  localparam int FU_IDX_BR   = 2;
  localparam int FU_IDX_MLS  = 3;
  localparam int FU_IDX_GEMM = 4;

  typedef enum logic [1:0] {
    FUST_EMPTY = 2'd0,
    FUST_WAIT  = 2'd1,
    FUST_RDY   = 2'd2,
    FUST_EX    = 2'd3
  } fust_state_e;

  typedef logic [NUM_FU-1:0] age_row_t;

  // Slot is still waiting to issue (contends for arbitration).
  function automatic logic is_pending(input fust_state_e s);
    return (s == FUST_WAIT) || (s == FUST_RDY);
  endfunction

endpackage

// File: rtl/issue_age_matrix.sv
// Age matrix for the issue slots: older_reg[i][j]=1 means slot i is older than slot j.
// Updated on alloc and squash; produces the one-hot oldest-eligible winner.
module issue_age_matrix #(
  parameter int NUM_FU = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_FU-1:0] alloc_oh,
  input  logic [NUM_FU-1:0] occupied,
  input  logic [NUM_FU-1:0] squash,
  input  logic [NUM_FU-1:0] eligible,
  input  logic              grant_en,
  output logic [NUM_FU-1:0] win_oh
);

  logic [NUM_FU-1:0] older_reg [NUM_FU];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_row
      logic [NUM_FU-1:0] row_next;
      logic              blocked;

      // A new arrival is younger than everything currently resident.
      always_comb begin
        row_next = older_reg[gi];
        if (alloc_oh[gi]) begin
          row_next = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
          if (alloc_oh[j]) begin
            row_next[j] = occupied[gi];
          end
          if (squash[gi] || squash[j]) begin
            row_next[j] = 1'b0;
          end
        end
        row_next[gi] = 1'b0;
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          older_reg[gi] <= '0;
        end else begin
          older_reg[gi] <= row_next;
        end
      end

      // Column scan: any eligible slot older than this one blocks it.
      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < NUM_FU; j++) begin
          blocked = blocked | (eligible[j] & older_reg[j][gi]);
        end
      end

      assign win_oh[gi] = grant_en & eligible[gi] & ~blocked;
    end
  endgenerate

endmodule

// File: rtl/issue_arbiter.sv
// Oldest-first issue scheduler over the FUST slots, with a registered one-hot grant.
// Define ISSUE_ARB_PERF_EN to build the per-slot lost-arbitration counters on stall_cnt.
module issue_arbiter #(
  parameter int                NUM_FU         = 5,
  parameter logic [NUM_FU-1:0] SPEC_HOLD_MASK = 5'b11010
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 alloc_en,
  input  logic [NUM_FU-1:0]    alloc_fu,
  input  logic                 alloc_spec,
  input  logic                 freeze,
  input  logic [NUM_FU-1:0]    src_rdy,
  input  logic [NUM_FU-1:0]    fu_busy,
  input  logic [NUM_FU-1:0]    fu_done,
  input  logic                 branch_resolved,
  input  logic                 branch_miss,
  output logic [NUM_FU-1:0]    grant,
  output logic [NUM_FU*2-1:0]  slot_state,
  output logic [NUM_FU-1:0]    alloc_ready,
  output logic [NUM_FU*16-1:0] stall_cnt
);
  import datapath_pkg::*;

  logic [NUM_FU-1:0] alloc_hit;
  logic              alloc_valid;
  logic [NUM_FU-1:0] alloc_oh;
  logic [NUM_FU-1:0] occupied;
  logic [NUM_FU-1:0] candidate;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] squash;
  logic [NUM_FU-1:0] win_oh;
  logic [NUM_FU-1:0] grant_reg;

  assign alloc_hit   = alloc_fu & alloc_ready;
  assign alloc_valid = alloc_en & ~freeze & ~branch_miss & (|alloc_hit);
  assign alloc_oh    = alloc_valid ? alloc_hit : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
      fust_state_e state_reg;
      logic        spec_reg;

      assign occupied[gi]          = (state_reg != FUST_EMPTY);
      assign alloc_ready[gi]       = (state_reg == FUST_EMPTY) ||
                                     ((state_reg == FUST_EX) && fu_done[gi]);
      assign candidate[gi]         = ((state_reg == FUST_WAIT) && src_rdy[gi]) ||
                                     (state_reg == FUST_RDY);
      assign eligible[gi]          = candidate[gi] & ~fu_busy[gi] &
                                     ~(spec_reg & SPEC_HOLD_MASK[gi]) & ~freeze;
      // The branch unit always holds the mispredicted branch itself.
      assign squash[gi]            = branch_miss & (spec_reg | (gi == FU_IDX_BR));
      assign slot_state[gi*2 +: 2] = state_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state_reg <= FUST_EMPTY;
          spec_reg  <= 1'b0;
        end else if (squash[gi]) begin
          state_reg <= FUST_EMPTY;
          spec_reg  <= 1'b0;
        end else begin
          unique case (state_reg)
            FUST_EMPTY: if (alloc_oh[gi]) state_reg <= FUST_WAIT;
            FUST_WAIT: begin
              if (win_oh[gi]) begin
                state_reg <= FUST_EX;
              end else if (candidate[gi] && !freeze) begin
                state_reg <= FUST_RDY;
              end
            end
            FUST_RDY:   if (win_oh[gi]) state_reg <= FUST_EX;
            FUST_EX: begin
              if (fu_done[gi]) begin
                state_reg <= alloc_oh[gi] ? FUST_WAIT : FUST_EMPTY;
              end
            end
            default:    state_reg <= FUST_EMPTY;
          endcase

          if (alloc_oh[gi]) begin
            spec_reg <= alloc_spec & ~branch_resolved;
          end else if (branch_resolved || ((state_reg == FUST_EX) && fu_done[gi])) begin
            spec_reg <= 1'b0;
          end
        end
      end

`ifdef ISSUE_ARB_PERF_EN
      logic [15:0] stall_reg;

      // Counts cycles an eligible slot loses to an older one; resets once it leaves WAIT/RDY.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          stall_reg <= '0;
        end else if (win_oh[gi] || squash[gi]) begin
          stall_reg <= '0;
        end else if (eligible[gi] && (stall_reg != 16'hFFFF)) begin
          stall_reg <= stall_reg + 16'd1;
        end
      end

      assign stall_cnt[gi*16 +: 16] = stall_reg;
`else
      assign stall_cnt[gi*16 +: 16] = 16'd0;
`endif
    end
  endgenerate

  issue_age_matrix #(
    .NUM_FU (NUM_FU)
  ) u_age (
    .CLK      (CLK),
    .RST      (RST),
    .alloc_oh (alloc_oh),
    .occupied (occupied),
    .squash   (squash),
    .eligible (eligible),
    .grant_en (~branch_miss),
    .win_oh   (win_oh)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_reg <= '0;
    end else begin
      grant_reg <= win_oh;
    end
  end

  assign grant = grant_reg;

  alloc_to_busy_slot: assert property (@(posedge CLK) disable iff (RST)
    (alloc_en && !freeze && !branch_miss) |-> ((alloc_fu & alloc_ready) != '0))
    else $error("issue_arbiter: alloc to non-ready slot %b", alloc_fu);

  grant_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(grant))
    else $error("issue_arbiter: grant not one-hot %b", grant);

endmodule

// File: tb/tb_issue_arbiter.sv
// Scoreboarded random + directed bench for issue_arbiter; reference model orders slots by alloc sequence number.
module tb_issue_arbiter;
  import datapath_pkg::*;

  localparam int N = 5;
  localparam logic [N-1:0] HOLD = 5'b11010;
  localparam int S_EMPTY = int'(FUST_EMPTY);
  localparam int S_WAIT  = int'(FUST_WAIT);
  localparam int S_RDY   = int'(FUST_RDY);
  localparam int S_EX    = int'(FUST_EX);

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           alloc_en = 1'b0;
  logic [N-1:0]   alloc_fu = '0;
  logic           alloc_spec = 1'b0;
  logic           freeze = 1'b0;
  logic [N-1:0]   src_rdy = '0;
  logic [N-1:0]   fu_busy = '0;
  logic [N-1:0]   fu_done = '0;
  logic           branch_resolved = 1'b0;
  logic           branch_miss = 1'b0;
  logic [N-1:0]   grant;
  logic [2*N-1:0] slot_state;
  logic [N-1:0]   alloc_ready;
  logic [16*N-1:0] stall_cnt;

  issue_arbiter #(.NUM_FU(N), .SPEC_HOLD_MASK(HOLD)) dut (
    .CLK(CLK), .RST(RST), .alloc_en(alloc_en), .alloc_fu(alloc_fu), .alloc_spec(alloc_spec),
    .freeze(freeze), .src_rdy(src_rdy), .fu_busy(fu_busy), .fu_done(fu_done),
    .branch_resolved(branch_resolved), .branch_miss(branch_miss), .grant(grant),
    .slot_state(slot_state), .alloc_ready(alloc_ready), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0]    grant;
    logic [2*N-1:0]  st;
    logic [16*N-1:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int m_st[N];
  bit m_spec[N];
  int m_seq[N];
  int m_stall[N];
  int seq_ctr;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = S_EMPTY; m_spec[i] = 1'b0; m_seq[i] = 0; m_stall[i] = 0;
    end
    seq_ctr = 0;
  endtask

  // One cycle: called at a negedge, drives inputs, predicts post-edge outputs, returns at next negedge.
  task automatic step(input logic ae, input logic [N-1:0] afu, input logic aspec, input logic frz,
                      input logic [N-1:0] srdy, input logic [N-1:0] busy, input logic [N-1:0] done,
                      input logic bres, input logic bmiss);
    logic [N-1:0] rdy, cand, elig, win;
    bit sq, valid;
    int best, k, nst;
    exp_t e;
    alloc_en = ae; alloc_fu = afu; alloc_spec = aspec; freeze = frz; src_rdy = srdy;
    fu_busy = busy; fu_done = done; branch_resolved = bres; branch_miss = bmiss;
    for (int i = 0; i < N; i++)
      rdy[i] = (m_st[i] == S_EMPTY) || (m_st[i] == S_EX && done[i]);
    #1;
    check("alloc_ready", 80'(alloc_ready), 80'(rdy));
    valid = ae && !frz && !bmiss && ((afu & rdy) != '0);
    k = -1;
    if (valid) for (int i = 0; i < N; i++) if (afu[i] && rdy[i]) k = i;
    best = -1;
    for (int i = 0; i < N; i++) begin
      cand[i] = (m_st[i] == S_WAIT && srdy[i]) || (m_st[i] == S_RDY);
      elig[i] = cand[i] && !busy[i] && !(m_spec[i] && HOLD[i]) && !frz;
      if (!bmiss && elig[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    end
    win = (best >= 0) ? N'(1 << best) : '0;
    for (int i = 0; i < N; i++) begin
      sq = bmiss && (i == FU_IDX_BR || m_spec[i]);
      nst = m_st[i];
      case (m_st[i])
        S_EMPTY: if (k == i) nst = S_WAIT;
        S_WAIT:  if (win[i]) nst = S_EX; else if (cand[i] && !frz) nst = S_RDY;
        S_RDY:   if (win[i]) nst = S_EX;
        default: if (done[i]) nst = (k == i) ? S_WAIT : S_EMPTY;
      endcase
      if (sq) begin
        nst = S_EMPTY; m_spec[i] = 1'b0;
      end else if (k == i) begin
        m_spec[i] = aspec && !bres;
      end else if (bres || (m_st[i] == S_EX && done[i])) begin
        m_spec[i] = 1'b0;
      end
      if (k == i) begin
        m_seq[i] = seq_ctr; seq_ctr++;
      end
      if (win[i] || sq) m_stall[i] = 0;
      else if (elig[i] && m_stall[i] < 65535) m_stall[i]++;
      m_st[i] = nst;
      e.st[2*i +: 2] = 2'(nst);
`ifdef ISSUE_ARB_PERF_EN
      e.stall[16*i +: 16] = 16'(m_stall[i]);
`else
      e.stall[16*i +: 16] = 16'd0;
`endif
    end
    e.grant = win;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic idle(input logic [N-1:0] srdy, input logic [N-1:0] busy, input logic [N-1:0] done);
    step(1'b0, '0, 1'b0, 1'b0, srdy, busy, done, 1'b0, 1'b0);
  endtask

  task automatic alloc(input logic [N-1:0] fu, input logic spec, input logic [N-1:0] srdy);
    step(1'b1, fu, spec, 1'b0, srdy, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the registered outputs against the scoreboard after every edge.
  initial begin
    exp_t e;
    int txn = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d grant=%b state=%b", txn, grant, slot_state);
        check("grant", 80'(grant), 80'(e.grant));
        check("slot_state", 80'(slot_state), 80'(e.st));
        check("stall_cnt", stall_cnt, e.stall);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] done, srdy, busy, rdy, afu;
    logic ae, aspec, frz, bres, bmiss;
    int picks[$];
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_grant", 80'(grant), 80'(0));
    check("rst_state", 80'(slot_state), 80'(0));
    check("rst_ready", 80'(alloc_ready), 80'(5'b11111));
    check("rst_stall", stall_cnt, 80'(0));
    @(negedge CLK);

    // Minimum latency alloc -> grant, then completion.
    alloc(5'b00001, 1'b0, 5'b00001);
    idle(5'b00001, '0, '0);
    check("t1_grant", 80'(grant), 80'(5'b00001));
    check("t1_ex", 80'(slot_state[1:0]), 80'(S_EX));
    idle('0, '0, 5'b00001);
    check("t1_empty", 80'(slot_state[1:0]), 80'(S_EMPTY));

    // Age order LD/ST, GEMM, ALU.
    alloc(5'b00010, 1'b0, '0);
    alloc(5'b10000, 1'b0, '0);
    alloc(5'b00001, 1'b0, '0);
    idle(5'b11111, '0, '0);
    check("t2_g0", 80'(grant), 80'(5'b00010));
    idle(5'b11111, '0, '0);
    check("t2_g1", 80'(grant), 80'(5'b10000));
    idle(5'b11111, '0, '0);
    check("t2_g2", 80'(grant), 80'(5'b00001));
    idle('0, '0, 5'b10011);

    // Speculative LD/ST held until branch_resolved.
    alloc(5'b00010, 1'b1, 5'b00010);
    repeat (3) idle(5'b00010, '0, '0);
    check("t3_held", 80'(grant), 80'(0));
    check("t3_rdy", 80'(slot_state[3:2]), 80'(S_RDY));
    step(1'b0, '0, 1'b0, 1'b0, 5'b00010, '0, '0, 1'b1, 1'b0);
    idle(5'b00010, '0, '0);
    check("t3_grant", 80'(grant), 80'(5'b00010));
    idle('0, '0, 5'b00010);

    // Squash of speculative LD/ST and the branch slot.
    alloc(5'b00010, 1'b1, '0);
    alloc(5'b00100, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 5'b00110, '0, '0, 1'b0, 1'b1);
    check("t4_state", 80'(slot_state), 80'(0));
    check("t4_grant", 80'(grant), 80'(0));
    check("t4_ready", 80'(alloc_ready), 80'(5'b11111));

    // Zero-latency slot reuse.
    alloc(5'b00001, 1'b0, 5'b00001);
    idle(5'b00001, '0, '0);
    step(1'b1, 5'b00001, 1'b0, 1'b0, 5'b00001, '0, 5'b00001, 1'b0, 1'b0);
    check("t5_wait", 80'(slot_state[1:0]), 80'(S_WAIT));
    idle(5'b00001, '0, '0);
    check("t5_grant", 80'(grant), 80'(5'b00001));
    idle('0, '0, 5'b00001);

    // Older GEMM blocked by fu_busy while ALU issues.
    alloc(5'b10000, 1'b0, '0);
    alloc(5'b00001, 1'b0, '0);
    repeat (3) idle(5'b10001, 5'b10000, '0);
    check("t6_stall4", 80'(stall_cnt[64 +: 16]), 80'(0));
    check("t6_stall0", 80'(stall_cnt[0 +: 16]), 80'(0));
    idle(5'b10000, '0, 5'b00001);
    idle('0, '0, '0);
    check("t6_gemm", 80'(slot_state[9:8]), 80'(S_EX));
    idle('0, '0, 5'b10000);

    // Asynchronous reset while a grant is high.
    alloc(5'b00001, 1'b0, 5'b00001);
    idle(5'b00001, '0, '0);
    check("ar_pre", 80'(grant), 80'(5'b00001));
    #2 RST = 1'b1;
    #1;
    check("ar_grant", 80'(grant), 80'(0));
    check("ar_state", 80'(slot_state), 80'(0));
    check("ar_ready", 80'(alloc_ready), 80'(5'b11111));
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        done[i] = (m_st[i] == S_EX) && ($urandom_range(0, 99) < 40);
        rdy[i]  = (m_st[i] == S_EMPTY) || (m_st[i] == S_EX && done[i]);
        busy[i] = ($urandom_range(0, 3) == 0);
      end
      srdy  = N'($urandom);
      ae    = ($urandom_range(0, 1) == 1);
      aspec = ($urandom_range(0, 3) == 0);
      frz   = ($urandom_range(0, 9) == 0);
      bres  = ($urandom_range(0, 9) == 0);
      bmiss = ($urandom_range(0, 24) == 0);
      picks.delete();
      for (int i = 0; i < N; i++) if (rdy[i]) picks.push_back(i);
      afu = '0;
      if (ae && picks.size() > 0) afu = N'(1 << picks[$urandom_range(0, picks.size() - 1)]);
      else ae = 1'b0;
      step(ae, afu, aspec, frz, srdy, busy, done, bres, bmiss);
    end
    idle('0, '0, '0);
    @(negedge CLK);
    check("scoreboard_drained", 80'(exp_q.size()), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
